// File: rtl/rob_squash_ctrl_pkg.sv
// Shared types for the branch-mispredict recovery sequencer.
//   DEPTH_DEF / N_DEF : default ROB depth and squash lanes per cycle
//   squash_state_t    : recovery sequencer states
//   ROB_ENTRY_PACKET  : ROB entry fields used for rollback (t = new preg, t_old = previous mapping)
package rob_squash_ctrl_pkg;

    localparam int DEPTH_DEF = 32;
    localparam int N_DEF     = 3;
    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } squash_state_t;

    typedef struct packed {
        logic [AREG_W-1:0] arch_reg;
        logic [PREG_W-1:0] t;
        logic [PREG_W-1:0] t_old;
    } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_squash_ctrl_if.sv
// Bundle between the recovery sequencer, the ROB and the rename state.
//   master : the sequencer (takes mispredict/ROB pointers/read data,
//            drives read indices, restore lanes, tail reload and stalls)
//   slave  : the ROB / map table / free list side
interface rob_squash_ctrl_if
    import rob_squash_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int N     = N_DEF
) ();

    localparam int LOG_DEPTH = $clog2(DEPTH);

    logic                            mispredict_valid;
    logic [LOG_DEPTH-1:0]            mispredict_idx;
    logic [LOG_DEPTH-1:0]            rob_head;
    logic [LOG_DEPTH-1:0]            rob_tail;
    ROB_ENTRY_PACKET [N-1:0]         squash_data;
    logic [N-1:0][LOG_DEPTH-1:0]     squash_idx;
    logic [N-1:0]                    restore_valid;
    ROB_ENTRY_PACKET [N-1:0]         restore_data;
    logic                            new_tail_valid;
    logic [LOG_DEPTH-1:0]            new_tail;
    logic                            dispatch_stall;
    logic                            retire_stall;
    logic                            busy;

    modport master (
        input  mispredict_valid, mispredict_idx, rob_head, rob_tail, squash_data,
        output squash_idx, restore_valid, restore_data, new_tail_valid, new_tail,
               dispatch_stall, retire_stall, busy
    );

    modport slave (
        output mispredict_valid, mispredict_idx, rob_head, rob_tail, squash_data,
        input  squash_idx, restore_valid, restore_data, new_tail_valid, new_tail,
               dispatch_stall, retire_stall, busy
    );

endinterface

// File: rtl/rob_squash_ctrl_age_cmp.sv
// ROB age helper: age(x) = (x - head) mod 2^LOG_DEPTH, plus an older-than compare.
//   head    : ROB head (oldest entry)
//   a, b    : ROB indices to compare
//   age_a/b : ages of a and b relative to head
//   a_older : a is strictly older than b
module rob_squash_ctrl_age_cmp #(
    parameter int LOG_DEPTH = 5
) (
    input  logic [LOG_DEPTH-1:0] head,
    input  logic [LOG_DEPTH-1:0] a,
    input  logic [LOG_DEPTH-1:0] b,
    output logic [LOG_DEPTH-1:0] age_a,
    output logic [LOG_DEPTH-1:0] age_b,
    output logic                 a_older
);

    // Natural LOG_DEPTH-bit wrap gives the modulo.
    assign age_a   = a - head;
    assign age_b   = b - head;
    assign a_older = (age_a < age_b);

endmodule

// File: rtl/rob_squash_ctrl.sv
// Branch-mispredict recovery sequencer. Walks the ROB from the youngest entry
// back to the mispredicting branch, up to N entries per cycle, presenting each
// squashed entry youngest-first for map-table / free-list rollback, then pulses
// a tail reload to one past the branch.
//   clock : system clock
//   reset : asynchronous, active-low
//   bus   : master side of rob_squash_ctrl_if
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no recovery in progress; lanes idle
// WALK  | presenting squash groups from walk_ptr downward
// DONE  | walk finished; new_tail_valid pulses with target + 1
module rob_squash_ctrl
    import rob_squash_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int N     = N_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    rob_squash_ctrl_if.master     bus
);

    localparam int LOG_DEPTH = $clog2(DEPTH);
    localparam logic [LOG_DEPTH-1:0] N_IDX   = LOG_DEPTH'(N);
    localparam logic [LOG_DEPTH-1:0] IDX_ONE = LOG_DEPTH'(1);

    squash_state_t        state;
    logic [LOG_DEPTH-1:0] target;
    logic [LOG_DEPTH-1:0] walk_ptr;
    logic [LOG_DEPTH-1:0] remaining;
    logic                 new_tail_valid_q;
    logic [LOG_DEPTH-1:0] new_tail_q;
    logic                 busy_q;

    logic [LOG_DEPTH-1:0] k;
    logic [LOG_DEPTH-1:0] from_ptr;
    logic [LOG_DEPTH-1:0] age_idx;
    logic [LOG_DEPTH-1:0] age_from;
    logic [LOG_DEPTH-1:0] rem_new;
    logic                 idx_older_tgt;
    logic                 retarget;
    logic [N-1:0]         lane_valid;

    logic                 unused_from_older;
    logic [LOG_DEPTH-1:0] unused_tgt_age_a;
    logic [LOG_DEPTH-1:0] unused_tgt_age_b;
    logic                 unused_age;

    assign k = (remaining < N_IDX) ? remaining : N_IDX;

    // Youngest still-pending index the new walk distance is measured from.
    // In DONE walk_ptr already equals target, but target is the intended reference.
    always_comb begin
        from_ptr = walk_ptr;
        case (state)
            IDLE:    from_ptr = bus.rob_tail - IDX_ONE;
            WALK:    from_ptr = walk_ptr;
            default: from_ptr = target;
        endcase
    end

    rob_squash_ctrl_age_cmp #(.LOG_DEPTH(LOG_DEPTH)) u_age_walk (
        .head    (bus.rob_head),
        .a       (bus.mispredict_idx),
        .b       (from_ptr),
        .age_a   (age_idx),
        .age_b   (age_from),
        .a_older (unused_from_older)
    );

    rob_squash_ctrl_age_cmp #(.LOG_DEPTH(LOG_DEPTH)) u_age_tgt (
        .head    (bus.rob_head),
        .a       (bus.mispredict_idx),
        .b       (target),
        .age_a   (unused_tgt_age_a),
        .age_b   (unused_tgt_age_b),
        .a_older (idx_older_tgt)
    );

    assign unused_age = ^{unused_from_older, unused_tgt_age_a, unused_tgt_age_b};

    assign rem_new  = age_from - age_idx;
    assign retarget = bus.mispredict_valid && idx_older_tgt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            target           <= '0;
            walk_ptr         <= '0;
            remaining        <= '0;
            new_tail_valid_q <= 1'b0;
            new_tail_q       <= '0;
            busy_q           <= 1'b0;
        end else begin
            new_tail_valid_q <= 1'b0;
            new_tail_q       <= '0;
            case (state)
                IDLE: begin
                    if (bus.mispredict_valid) begin
                        target    <= bus.mispredict_idx;
                        walk_ptr  <= from_ptr;
                        remaining <= rem_new;
                        busy_q    <= 1'b1;
                        if (rem_new == '0) begin
                            state            <= DONE;
                            new_tail_valid_q <= 1'b1;
                            new_tail_q       <= bus.mispredict_idx + IDX_ONE;
                        end else begin
                            state <= WALK;
                        end
                    end
                end
                WALK: begin
                    walk_ptr <= walk_ptr - k;
                    if (retarget) begin
                        // Distance to an older branch always exceeds the current
                        // group, so the walk continues.
                        target    <= bus.mispredict_idx;
                        remaining <= rem_new - k;
                    end else if (remaining == k) begin
                        remaining        <= '0;
                        state            <= DONE;
                        new_tail_valid_q <= 1'b1;
                        new_tail_q       <= target + IDX_ONE;
                    end else begin
                        remaining <= remaining - k;
                    end
                end
                DONE: begin
                    if (retarget) begin
                        target    <= bus.mispredict_idx;
                        walk_ptr  <= target;
                        remaining <= rem_new;
                        if (rem_new == '0) begin
                            state            <= DONE;
                            new_tail_valid_q <= 1'b1;
                            new_tail_q       <= bus.mispredict_idx + IDX_ONE;
                        end else begin
                            state <= WALK;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Lane 0 is the youngest entry of the group; unused lanes park on walk_ptr.
    always_comb begin
        lane_valid       = '0;
        bus.squash_idx   = '0;
        bus.restore_data = '0;
        for (int i = 0; i < N; i++) begin
            lane_valid[i]       = (state == WALK) && (LOG_DEPTH'(i) < k);
            bus.squash_idx[i]   = lane_valid[i] ? (walk_ptr - LOG_DEPTH'(i)) : walk_ptr;
            bus.restore_data[i] = lane_valid[i] ? bus.squash_data[i] : '0;
        end
    end

    assign bus.restore_valid  = lane_valid;
    assign bus.new_tail_valid = new_tail_valid_q;
    assign bus.new_tail       = new_tail_q;
    assign bus.busy           = busy_q;
    assign bus.dispatch_stall = busy_q || bus.mispredict_valid;
    assign bus.retire_stall   = busy_q || bus.mispredict_valid;

endmodule

// File: tb/tb_rob_squash_ctrl.sv
module tb_rob_squash_ctrl;
    import rob_squash_ctrl_pkg::*;

    localparam int DEPTH = 32;
    localparam int N     = 3;

    typedef struct packed {
        logic [31:0]     cyc;
        logic [2:0]      mask;
        logic [2:0][4:0] idx;
        logic            ntv;
        logic [4:0]      nt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0     = 0;
    int   final_tgt = 0;

    exp_t            exp_q[$];
    exp_t            mon_e;
    ROB_ENTRY_PACKET rob_mem [DEPTH];
    bit              squashed [DEPTH];

    rob_squash_ctrl_if #(.DEPTH(DEPTH), .N(N)) bus ();

    rob_squash_ctrl #(.DEPTH(DEPTH), .N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ROB read port model: same-cycle combinational read
    always_comb begin
        bus.squash_data = '0;
        for (int i = 0; i < N; i++)
            bus.squash_data[i] = rob_mem[bus.squash_idx[i]];
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int age(int x);
        return (x - int'(bus.rob_head)) & (DEPTH - 1);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(int dc, logic [2:0] m, int i0, int i1, int i2, logic ntv, int nt);
        exp_t e;
        e.cyc    = 32'(c0 + dc);
        e.mask   = m;
        e.idx[0] = 5'(i0);
        e.idx[1] = 5'(i1);
        e.idx[2] = 5'(i2);
        e.ntv    = ntv;
        e.nt     = 5'(nt);
        exp_q.push_back(e);
    endtask

    task automatic begin_scn(int head, int tail, int tgt);
        bus.rob_head = 5'(head);
        bus.rob_tail = 5'(tail);
        final_tgt    = tgt;
        for (int i = 0; i < DEPTH; i++) squashed[i] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
        chk("drain_pending_expectations", exp_q.size(), 0);
    endtask

    // Monitor: pops one expectation whenever the DUT presents lanes or a tail pulse
    always @(negedge clock) begin
        if (reset && (bus.restore_valid != '0 || bus.new_tail_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'({bus.restore_valid, bus.new_tail_valid}), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_cycle", cyc, int'(mon_e.cyc));
                chk("restore_valid", int'(bus.restore_valid), int'(mon_e.mask));
                chk("new_tail_valid", int'(bus.new_tail_valid), int'(mon_e.ntv));
                if (mon_e.ntv) chk("new_tail", int'(bus.new_tail), int'(mon_e.nt));
                for (int i = 0; i < N; i++) begin
                    if (mon_e.mask != '0)
                        chk($sformatf("squash_idx[%0d]", i), int'(bus.squash_idx[i]), int'(mon_e.idx[i]));
                    if (mon_e.mask[i] && bus.restore_valid[i]) begin
                        chk($sformatf("restore_data[%0d]", i), int'(bus.restore_data[i]),
                            int'(rob_mem[mon_e.idx[i]]));
                        chk("squashed_once", int'(squashed[bus.squash_idx[i]]), 0);
                        chk("squash_younger_than_target",
                            int'(age(int'(bus.squash_idx[i])) > age(final_tgt)), 1);
                        squashed[bus.squash_idx[i]] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mispredict_valid = 1'b0;
        bus.mispredict_idx   = '0;
        bus.rob_head         = '0;
        bus.rob_tail         = '0;
        for (int i = 0; i < DEPTH; i++)
            rob_mem[i] = '{arch_reg: AREG_W'(i), t: PREG_W'(i + 32), t_old: PREG_W'(63 - i)};

        // reset state
        #2 reset = 1'b0;
        #10;
        chk("reset_restore_valid", int'(bus.restore_valid), 0);
        chk("reset_new_tail_valid", int'(bus.new_tail_valid), 0);
        chk("reset_new_tail", int'(bus.new_tail), 0);
        chk("reset_squash_idx", int'(bus.squash_idx), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_dispatch_stall", int'(bus.dispatch_stall), 0);
        chk("reset_retire_stall", int'(bus.retire_stall), 0);
        step();
        reset = 1'b1;
        step();
        step();

        // basic walk: head 0, tail 10, branch 2
        begin_scn(0, 10, 2);
        c0 = cyc;
        push(1, 3'b111, 9, 8, 7, 1'b0, 0);
        push(2, 3'b111, 6, 5, 4, 1'b0, 0);
        push(3, 3'b001, 3, 3, 3, 1'b0, 0);
        push(4, 3'b000, 0, 0, 0, 1'b1, 3);
        bus.mispredict_idx   = 5'd2;
        bus.mispredict_valid = 1'b1;
        #1 chk("basic_stall_c0", int'(bus.dispatch_stall), 1);
        step();
        bus.mispredict_valid = 1'b0;
        chk("basic_busy_c1", int'(bus.busy), 1);
        step(); step(); step();
        chk("basic_busy_c4", int'(bus.busy), 1);
        step();
        chk("basic_busy_c5", int'(bus.busy), 0);
        chk("basic_stall_c5", int'(bus.dispatch_stall), 0);
        drain();

        // wrap: head 28, tail 4, branch 30
        begin_scn(28, 4, 30);
        c0 = cyc;
        push(1, 3'b111, 3, 2, 1, 1'b0, 0);
        push(2, 3'b011, 0, 31, 0, 1'b0, 0);
        push(3, 3'b000, 0, 0, 0, 1'b1, 31);
        bus.mispredict_idx   = 5'd30;
        bus.mispredict_valid = 1'b1;
        step();
        bus.mispredict_valid = 1'b0;
        step(); step(); step();
        drain();

        // branch is youngest: head 5, tail 9, branch 8
        begin_scn(5, 9, 8);
        chk("young_stall_pre", int'(bus.dispatch_stall), 0);
        c0 = cyc;
        push(1, 3'b000, 0, 0, 0, 1'b1, 9);
        bus.mispredict_idx   = 5'd8;
        bus.mispredict_valid = 1'b1;
        #1;
        chk("young_dispatch_stall_c0", int'(bus.dispatch_stall), 1);
        chk("young_retire_stall_c0", int'(bus.retire_stall), 1);
        step();
        bus.mispredict_valid = 1'b0;
        #1;
        chk("young_dispatch_stall_c1", int'(bus.dispatch_stall), 1);
        chk("young_retire_stall_c1", int'(bus.retire_stall), 1);
        step();
        chk("young_dispatch_stall_c2", int'(bus.dispatch_stall), 0);
        chk("young_retire_stall_c2", int'(bus.retire_stall), 0);
        drain();

        // older retarget: head 0, tail 20, branch 15, then 10 in c1, younger 17 in c2
        begin_scn(0, 20, 10);
        c0 = cyc;
        push(1, 3'b111, 19, 18, 17, 1'b0, 0);
        push(2, 3'b111, 16, 15, 14, 1'b0, 0);
        push(3, 3'b111, 13, 12, 11, 1'b0, 0);
        push(4, 3'b000, 0, 0, 0, 1'b1, 11);
        bus.mispredict_idx   = 5'd15;
        bus.mispredict_valid = 1'b1;
        step();
        bus.mispredict_idx   = 5'd10;
        step();
        bus.mispredict_idx   = 5'd17;
        step();
        bus.mispredict_valid = 1'b0;
        step(); step(); step();
        chk("retarget_busy_end", int'(bus.busy), 0);
        drain();

        // reset mid-walk
        begin_scn(0, 10, 2);
        c0 = cyc;
        push(1, 3'b111, 9, 8, 7, 1'b0, 0);
        bus.mispredict_idx   = 5'd2;
        bus.mispredict_valid = 1'b1;
        step();
        bus.mispredict_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("rst_mid_restore_valid", int'(bus.restore_valid), 0);
        chk("rst_mid_restore_data", int'(bus.restore_data), 0);
        chk("rst_mid_squash_idx", int'(bus.squash_idx), 0);
        chk("rst_mid_new_tail_valid", int'(bus.new_tail_valid), 0);
        chk("rst_mid_new_tail", int'(bus.new_tail), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_dispatch_stall", int'(bus.dispatch_stall), 0);
        chk("rst_mid_retire_stall", int'(bus.retire_stall), 0);
        step(); step();
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            step();
            chk("rst_release_busy", int'(bus.busy), 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rob_squash_ctrl.md
# rob_squash_ctrl

Branch-mispredict recovery sequencer for the N-way ROB. On a mispredict it walks the ROB from youngest entry back toward the mispredicting branch, at most N entries per cycle, and presents each squashed entry to the map table and free list for rollback. When the walk finishes it commands the ROB to move its tail to one past the branch. Dispatch and retirement are held off for the whole recovery.

## Interface
- DEPTH, default `PHYS_REG_SZ_R10K: ROB entries; must be a power of two. LOG_DEPTH = $clog2(DEPTH).
- N, default `N: maximum entries squashed per cycle.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- mispredict_valid  in  1  a branch resolved as mispredicted this cycle.
- mispredict_idx  in  LOG_DEPTH  ROB index of that branch.
- rob_head  in  LOG_DEPTH  current ROB head (oldest entry).
- rob_tail  in  LOG_DEPTH  current ROB tail (one past youngest).
- squash_data  in  ROB_ENTRY_PACKET [N]  ROB read data at squash_idx[i], same cycle.
- squash_idx  out  [N][LOG_DEPTH]  ROB read indices; [0] is youngest.
- restore_valid  out  N  lane i carries a squashed entry.
- restore_data  out  ROB_ENTRY_PACKET [N]  squash_data[i] forwarded; consumers use fields t and t_old.
- new_tail_valid  out  1  one-cycle pulse: ROB loads tail from new_tail.
- new_tail  out  LOG_DEPTH  (branch_idx + 1) mod DEPTH.
- dispatch_stall  out  1  state != IDLE, or mispredict_valid.
- retire_stall  out  1  same as dispatch_stall.
- busy  out  1  state != IDLE.

## Operation
- Registers: state, target (branch idx), walk_ptr (next index to squash, youngest first), remaining (LOG_DEPTH bits).
- age(x) = (x - rob_head) mod DEPTH. All index math is modulo DEPTH via natural LOG_DEPTH-bit wrap.
- IDLE: on mispredict_valid, capture target = mispredict_idx, walk_ptr = rob_tail - 1, remaining = age(rob_tail - 1) - age(mispredict_idx). Go to DONE if remaining == 0, else WALK.
- WALK: k = min(N, remaining). Lanes 0..k-1 valid with squash_idx[i] = walk_ptr - i. Lanes >= k have valid 0 and squash_idx = walk_ptr. Update walk_ptr -= k and remaining -= k. Go to DONE when remaining reaches 0.
- DONE: pulse new_tail_valid with new_tail = target + 1, then go to IDLE. No lanes are valid.
- A mispredict that arrives in WALK with age(mispredict_idx) < age(target) retargets to the older branch:
  - target = mispredict_idx;
  - remaining = age(walk_ptr) - age(mispredict_idx), or that value minus k if it is applied in the same cycle as a group.
- Any other mispredict arriving in WALK or DONE is ignored, because it is younger and already squashed or pending.
- An older mispredict arriving in DONE also retargets:
  - walk_ptr = old target;
  - remaining = age(old target) - age(new idx);
  - next state is WALK if remaining > 0, else DONE again.
- Each entry is asserted on restore_valid exactly once.
- Lanes are presented youngest-first, so map-table rollback to t_old is applied in the correct order.

## Timing
- Reset values: state = IDLE, all outputs 0, squash_idx = 0, new_tail = 0.
- Mispredict at cycle 0: first squash group at cycle 1. With R entries to squash, the groups occupy cycles 1..ceil(R/N) and new_tail_valid is asserted in cycle ceil(R/N)+1.
- If the branch is the youngest entry (R = 0), new_tail_valid is asserted in cycle 1.
- The ROB holds head and tail constant while busy, with dispatch and retire stalled. The block relies on this.
- squash_data is combinational from the ROB for the same cycle. There is no added latency and restore_data is unregistered.
- Reset asserted mid-walk aborts the walk with no new_tail pulse. ROB, map table and free list are reset alongside.

## Structure
- The squash-state enum (IDLE, WALK, DONE) and ROB_ENTRY_PACKET belong in sys_defs.svh.
- A natural sub-module is rob_age_cmp: combinational age(x) and an older-than comparator. It is reused by the branch unit.

## Test plan
All scenarios use N=3, DEPTH=32.
- Basic walk: head=0, tail=10, mispredict idx 2.
  - c1: idx 9,8,7;
  - c2: idx 6,5,4;
  - c3: idx 3 only, lanes 1-2 invalid;
  - c4: new_tail=3 pulse;
  - c5: busy=0.
- Wrap: head=28, tail=4, idx 30.
  - c1: idx 3,2,1;
  - c2: idx 0,31;
  - c3: new_tail=31.
- Branch is youngest: head=5, tail=9, idx 8. No lane valid; c1 new_tail=9. Stalls are high only in c0 and c1.
- Older retarget: head=0, tail=20, idx 15.
  - c1: idx 19,18,17;
  - mispredict idx 10 in c1;
  - c2: idx 16,15,14;
  - c3: idx 13,12,11;
  - c4: new_tail=11.
  - A younger mispredict (idx 17) in c2 is ignored.
- Reset mid-walk: reset=0 during c2 of the basic walk. All outputs go to 0 immediately, there is no new_tail pulse, and IDLE holds after release.
- Every restore_valid lane matches squash_data[i] from a scoreboard ROB model. No index is squashed twice, and no index older than or equal to target is ever squashed.
